// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: XLEN immediate, pc-relative target and illegal flag over valid/ready.
// Latency: one cycle from input transfer to out_valid when the output register is free.
// Backpressure: output register plus one skid entry; in_ready is registered and low only while the skid is full.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [2:0]      ImmType,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    localparam logic [2:0] IMM_I  = 3'b000;
    localparam logic [2:0] IMM_S  = 3'b001;
    localparam logic [2:0] IMM_B  = 3'b010;
    localparam logic [2:0] IMM_U  = 3'b011;
    localparam logic [2:0] IMM_J  = 3'b100;
    localparam logic [2:0] IMM_Z  = 3'b101;
    localparam logic [2:0] IMM_SH = 3'b110;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            illegal;
    } res_t;

    res_t        or_q, or_d, sk_q, sk_d, res_c;
    logic        or_vld_q, or_vld_d, sk_vld_q, sk_vld_d;
    logic        accept, drain;
    logic [31:0] raw32;
    logic        illegal_c;
    logic        unused_opcode;

    // The opcode field carries no immediate bits.
    assign unused_opcode = ^instr_in[6:0];

    // raw32 is already sign-extended to 32 bits; zero-extended types have bit 31 clear,
    // so a single signed widening covers every type for XLEN=64.
    always_comb begin
        raw32     = 32'd0;
        illegal_c = 1'b0;
        case (ImmType)
            IMM_I:  raw32 = {{20{instr_in[31]}}, instr_in[31:20]};
            IMM_S:  raw32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            IMM_B:  raw32 = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                             instr_in[30:25], instr_in[11:8], 1'b0};
            IMM_U:  raw32 = {instr_in[31:12], 12'd0};
            IMM_J:  raw32 = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                             instr_in[20], instr_in[30:21], 1'b0};
            IMM_Z:  raw32 = {27'd0, instr_in[19:15]};
            IMM_SH: raw32 = (XLEN == 64) ? {26'd0, instr_in[25:20]}
                                         : {27'd0, instr_in[24:20]};
            default: illegal_c = 1'b1;
        endcase
        res_c.imm     = XLEN'($signed(raw32));
        res_c.target  = pc_in + res_c.imm;
        res_c.illegal = illegal_c;
    end

    assign in_ready = !sk_vld_q;
    assign accept   = in_valid && in_ready;
    assign drain    = or_vld_q && out_ready;

    always_comb begin
        or_d     = or_q;
        or_vld_d = or_vld_q;
        sk_d     = sk_q;
        sk_vld_d = sk_vld_q;
        if (flush) begin
            or_vld_d = 1'b0;
            sk_vld_d = 1'b0;
        end else if (!or_vld_q || drain) begin
            // Skid entry is older than any new beat, so it always moves up first.
            if (sk_vld_q) begin
                or_d     = sk_q;
                or_vld_d = 1'b1;
                sk_vld_d = accept;
                if (accept) begin
                    sk_d = res_c;
                end
            end else if (accept) begin
                or_d     = res_c;
                or_vld_d = 1'b1;
            end else begin
                or_vld_d = 1'b0;
            end
        end else if (accept) begin
            sk_d     = res_c;
            sk_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_q     <= '0;
            or_vld_q <= 1'b0;
            sk_q     <= '0;
            sk_vld_q <= 1'b0;
        end else begin
            or_q     <= or_d;
            or_vld_q <= or_vld_d;
            sk_q     <= sk_d;
            sk_vld_q <= sk_vld_d;
        end
    end

    assign out_valid = or_vld_q;
    assign imm       = or_q.imm;
    assign target    = or_q.target;
    assign illegal   = or_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe at XLEN=32 and XLEN=64 side by side, scoreboard-checked.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr_in;
    logic [63:0] pc_in;
    logic [2:0]  imm_type;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32, target32;
    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64, target64;

    imm_gen_pipe #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .instr_in(instr_in), .pc_in(pc_in[31:0]), .ImmType(imm_type),
        .out_valid(out_valid32), .out_ready(out_ready),
        .imm(imm32), .target(target32), .illegal(illegal32)
    );

    imm_gen_pipe #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .instr_in(instr_in), .pc_in(pc_in), .ImmType(imm_type),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm(imm64), .target(target64), .illegal(illegal64)
    );

    typedef struct {
        logic [31:0] imm32;
        logic [31:0] tgt32;
        logic [63:0] imm64;
        logic [63:0] tgt64;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    exp_t held;
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] t, input logic [31:0] ins, input logic [63:0] pc,
                         input logic [31:0] ei32, input logic [31:0] et32,
                         input logic [63:0] ei64, input logic [63:0] et64, input logic eill);
        imm_type  = t;
        instr_in  = ins;
        pc_in     = pc;
        in_valid  = 1'b1;
        cur.imm32 = ei32;
        cur.tgt32 = et32;
        cur.imm64 = ei64;
        cur.tgt64 = et64;
        cur.ill   = eill;
    endtask

    // Observe both handshakes mid-cycle, then advance past the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (out_valid32 && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(out_valid32), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("imm32",    64'(imm32),       64'(e.imm32));
                    chk("target32", 64'(target32),    64'(e.tgt32));
                    chk("illegal32", 64'(illegal32),  64'(e.ill));
                    chk("valid64",  64'(out_valid64), 64'd1);
                    chk("imm64",    imm64,            e.imm64);
                    chk("target64", target64,         e.tgt64);
                    chk("illegal64", 64'(illegal64),  64'(e.ill));
                end
            end
            if (in_valid && in_ready32) sb.push_back(cur);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && (sb.size() != 0 || out_valid32); k++) tick();
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
        chk("drain_out_valid", 64'(out_valid32), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr_in = 32'd0; pc_in = 64'd0; imm_type = 3'd0;
        cur = '{default: '0};

        #12;
        chk("rst_out_valid32", 64'(out_valid32), 64'd0);
        chk("rst_in_ready32",  64'(in_ready32),  64'd1);
        chk("rst_imm32",       64'(imm32),       64'd0);
        chk("rst_target32",    64'(target32),    64'd0);
        chk("rst_illegal32",   64'(illegal32),   64'd0);
        chk("rst_out_valid64", 64'(out_valid64), 64'd0);
        chk("rst_imm64",       imm64,            64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-beat latency
        out_ready = 1'b1;
        drive(3'b000, 32'hFFF00093, 64'h100, 32'hFFFFFFFF, 32'h000000FF,
              64'hFFFFFFFFFFFFFFFF, 64'h00000000000000FF, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("latency_out_valid32", 64'(out_valid32), 64'd1);
        chk("latency_out_valid64", 64'(out_valid64), 64'd1);
        tick();

        // Back-to-back stream covering every type
        drive(3'b010, 32'hFE000EE3, 64'h100, 32'hFFFFFFFC, 32'h000000FC,
              64'hFFFFFFFFFFFFFFFC, 64'h00000000000000FC, 1'b0);
        tick(); chk("stream_in_ready_b", 64'(in_ready32), 64'd1);
        drive(3'b100, 32'h0080006F, 64'h200, 32'h8, 32'h208, 64'h8, 64'h208, 1'b0);
        tick(); chk("stream_in_ready_j", 64'(in_ready32), 64'd1);
        drive(3'b011, 32'h800000B7, 64'h1000, 32'h80000000, 32'h80001000,
              64'hFFFFFFFF80000000, 64'hFFFFFFFF80001000, 1'b0);
        tick();
        drive(3'b110, 32'h03F09093, 64'h40, 32'h1F, 32'h5F, 64'h3F, 64'h7F, 1'b0);
        tick();
        drive(3'b101, 32'hFFFFF073, 64'h10, 32'h1F, 32'h2F, 64'h1F, 64'h2F, 1'b0);
        tick();
        drive(3'b111, 32'h12345678, 64'h300, 32'h0, 32'h300, 64'h0, 64'h300, 1'b1);
        tick();
        drive(3'b001, 32'hFE112E23, 64'h100, 32'hFFFFFFFC, 32'h000000FC,
              64'hFFFFFFFFFFFFFFFC, 64'h00000000000000FC, 1'b0);
        tick(); chk("stream_in_ready_s", 64'(in_ready64), 64'd1);
        drain_all();

        // Backpressure: A fills OR, B fills SK, C stalls
        out_ready = 1'b0;
        drive(3'b000, 32'h00500093, 64'h10, 32'h5, 32'h15, 64'h5, 64'h15, 1'b0);
        held = cur;
        tick();
        chk("bp_a_out_valid", 64'(out_valid32), 64'd1);
        chk("bp_a_in_ready",  64'(in_ready32),  64'd1);
        drive(3'b000, 32'h00600093, 64'h20, 32'h6, 32'h26, 64'h6, 64'h26, 1'b0);
        tick();
        chk("bp_b_in_ready32", 64'(in_ready32), 64'd0);
        chk("bp_b_in_ready64", 64'(in_ready64), 64'd0);
        drive(3'b000, 32'h00700093, 64'h30, 32'h7, 32'h37, 64'h7, 64'h37, 1'b0);
        tick();
        chk("bp_c_stalled_count", 64'(sb.size()), 64'd2);
        chk("bp_c_in_ready", 64'(in_ready32), 64'd0);
        tick();
        chk("bp_hold_imm32",    64'(imm32),    64'(held.imm32));
        chk("bp_hold_target64", target64,      held.tgt64);
        chk("bp_hold_valid",    64'(out_valid64), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", 64'(in_ready32), 64'd1);
        tick();
        drain_all();

        // Flush with OR and SK full and a beat offered on the same edge
        out_ready = 1'b0;
        drive(3'b000, 32'h01100093, 64'h0, 32'h11, 32'h11, 64'h11, 64'h11, 1'b0);
        tick();
        drive(3'b000, 32'h02200093, 64'h0, 32'h22, 32'h22, 64'h22, 64'h22, 1'b0);
        tick();
        drive(3'b000, 32'h03300093, 64'h0, 32'h33, 32'h33, 64'h33, 64'h33, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid32", 64'(out_valid32), 64'd0);
        chk("flush_out_valid64", 64'(out_valid64), 64'd0);
        chk("flush_in_ready32",  64'(in_ready32),  64'd1);
        chk("flush_in_ready64",  64'(in_ready64),  64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("flush_no_ghost", 64'(out_valid32), 64'd0);
        end

        // Asynchronous reset between edges with OR and SK occupied
        out_ready = 1'b0;
        drive(3'b011, 32'hFFFFF0B7, 64'h0, 32'hFFFFF000, 32'hFFFFF000,
              64'hFFFFFFFFFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0);
        tick();
        drive(3'b111, 32'h0, 64'h40, 32'h0, 32'h40, 64'h0, 64'h40, 1'b1);
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid32", 64'(out_valid32), 64'd0);
        chk("arst_out_valid64", 64'(out_valid64), 64'd0);
        chk("arst_in_ready32",  64'(in_ready32),  64'd1);
        chk("arst_imm32",       64'(imm32),       64'd0);
        chk("arst_target64",    target64,         64'd0);
        chk("arst_illegal64",   64'(illegal64),   64'd0);
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Restart, including target wrap modulo 2^XLEN
        out_ready = 1'b1;
        drive(3'b000, 32'h01000093, 64'hFFFFFFF0, 32'h10, 32'h0, 64'h10, 64'h100000000, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("restart_out_valid", 64'(out_valid32), 64'd1);
        drain_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
